// File: rtl/speech256_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | speech256_pkg : shared Speech256 types and constants                 |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package speech256_pkg;

  localparam int ALLO_W = 6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/allo_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | allo_fifo : synchronous allophone FIFO with sticky overflow           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module allo_fifo
  import speech256_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              push,
  input  logic [ALLO_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [ALLO_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              overflow
);

  localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);

  logic [ALLO_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;

  logic w_pop;
  logic w_push;
  logic w_drop;

  // Flush outranks both ports; a pop frees the slot a full-FIFO write needs.
  assign w_pop  = pop & ~flush & (r_count != '0);
  assign w_push = push & ~flush & ((r_count != c_full_cnt) | w_pop);
  assign w_drop = push & ~flush & ~w_push;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head     = r_mem[r_rd_ptr];
  assign full     = (r_count == c_full_cnt);
  assign empty    = (r_count == '0);
  assign level    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/allo_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | allo_sched : issues queued allophones, one strobe per load request    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module allo_sched
  import speech256_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              wr_en,
  input  logic [ALLO_W-1:0] wr_data,
  input  logic              flush,
  input  logic              ldq,
  output logic [ALLO_W-1:0] data_out,
  output logic              data_stb,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              busy
);

  sched_state_t      r_state;
  logic [ALLO_W-1:0] r_data_out;
  logic              r_data_stb;

  logic [ALLO_W-1:0] w_head;
  logic              w_empty;
  logic              w_pop;

  assign w_pop = (r_state == S_IDLE) & ldq & ~w_empty & ~flush;

  allo_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_an    (rst_an),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (w_pop),
    .flush     (flush),
    .head      (w_head),
    .full      (full),
    .empty     (w_empty),
    .level     (level),
    .overflow  (overflow)
  );

  // S_WAIT holds off until the controller has seen the strobe and dropped ldq.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      r_state    <= S_IDLE;
      r_data_out <= '0;
      r_data_stb <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_data_out <= w_head;
            r_data_stb <= 1'b1;
            r_state    <= S_WAIT;
          end else begin
            r_data_stb <= 1'b0;
          end
        end
        S_WAIT: begin
          r_data_stb <= 1'b0;
          if (!ldq) r_state <= S_IDLE;
        end
        default: begin
          r_data_stb <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out = r_data_out;
  assign data_stb = r_data_stb;
  assign empty    = w_empty;
  assign busy     = ~w_empty | ~ldq | (r_state == S_WAIT);

endmodule
`default_nettype wire
